// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the completion-bus arbiter: source encoding,
// ROB index width and the round-robin source selection helper.
package cdb_arbiter_pkg;

  localparam int ROB_SIZE_LOG = 4;
  localparam int DATA_W       = 32;

  typedef enum logic {
    CDB_SRC_ALU = 1'b0,
    CDB_SRC_SLB = 1'b1
  } cdb_src_e;

  // Pick the winning source among pending heads. When both are pending the
  // source that did not win last time is chosen.
  function automatic cdb_src_e pick_source(input logic alu_has,
                                           input logic slb_has,
                                           input cdb_src_e last_grant);
    cdb_src_e win;
    if (alu_has && slb_has) begin
      win = (last_grant == CDB_SRC_ALU) ? CDB_SRC_SLB : CDB_SRC_ALU;
    end else if (alu_has) begin
      win = CDB_SRC_ALU;
    end else begin
      win = CDB_SRC_SLB;
    end
    return win;
  endfunction

endpackage

// File: rtl/cdb_arbiter_result_fifo.sv
// result_fifo: small per-source result queue (value + ROB index).
// Pointers wrap naturally because DEPTH is a power of two. rst or flush
// empties the queue; push/pop are ignored when full/empty respectively.
module result_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] head_ptr_r;
  logic [PTR_W-1:0] tail_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic             clear_s;

  assign clear_s   = rst | flush;
  assign empty     = (count_r == CNT_W'(0));
  assign full      = (count_r == CNT_W'(DEPTH));
  assign push_ok_s = push & ~full & ~clear_s;
  assign pop_ok_s  = pop & ~empty & ~clear_s;
  assign head      = mem_r[head_ptr_r];

  // Storage write at the tail; contents need no reset since count gates use.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[tail_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push+pop keeps count.
  always_ff @(posedge clk) begin
    if (clear_s) begin
      head_ptr_r <= '0;
      tail_ptr_r <= '0;
      count_r    <= '0;
    end else begin
      if (push_ok_s) begin
        tail_ptr_r <= tail_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        head_ptr_r <= head_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: merges ALU and load results onto one registered common data
// bus, round-robin between sources. Optional feature macro: CDB_BYPASS_EN
// lets a result skip its empty queue when it wins in the arrival cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int QUEUE_DEPTH = 2,
  parameter int ROB_W       = ROB_SIZE_LOG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             pred_fail_flag,
  input  logic             alu_valid,
  input  logic [31:0]      alu_value,
  input  logic [ROB_W-1:0] alu_robid,
  output logic             alu_ready,
  input  logic             slb_valid,
  input  logic [31:0]      slb_value,
  input  logic [ROB_W-1:0] slb_robid,
  output logic             slb_ready,
  output logic             cdb_valid,
  output logic [31:0]      cdb_value,
  output logic [ROB_W-1:0] cdb_robid,
  output logic             cdb_src
);

  localparam int ENT_W = ROB_W + 32;

  logic             flush_s;
  logic             alu_full_s, alu_empty_s, slb_full_s, slb_empty_s;
  logic [ENT_W-1:0] alu_head_s, slb_head_s;
  logic             alu_acc_s, slb_acc_s;
  logic             alu_push_s, slb_push_s, alu_pop_s, slb_pop_s;
  logic             alu_has_s, slb_has_s;
  logic [ENT_W-1:0] alu_cand_s, slb_cand_s, win_data_s;
  logic             grant_s;
  cdb_src_e         winner_s;
  cdb_src_e         last_grant_r;

  assign flush_s   = rst | pred_fail_flag;
  assign alu_ready = rdy & ~alu_full_s;
  assign slb_ready = rdy & ~slb_full_s;
  assign alu_acc_s = alu_valid & alu_ready & ~flush_s;
  assign slb_acc_s = slb_valid & slb_ready & ~flush_s;

  result_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(ENT_W)) u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (pred_fail_flag),
    .push  (alu_push_s),
    .pop   (alu_pop_s),
    .wdata ({alu_robid, alu_value}),
    .head  (alu_head_s),
    .empty (alu_empty_s),
    .full  (alu_full_s)
  );

  result_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(ENT_W)) u_slb_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (pred_fail_flag),
    .push  (slb_push_s),
    .pop   (slb_pop_s),
    .wdata ({slb_robid, slb_value}),
    .head  (slb_head_s),
    .empty (slb_empty_s),
    .full  (slb_full_s)
  );

  // Candidate heads per source; with bypass an arrival stands in for an empty queue.
  always_comb begin
`ifdef CDB_BYPASS_EN
    alu_cand_s = alu_empty_s ? {alu_robid, alu_value} : alu_head_s;
    slb_cand_s = slb_empty_s ? {slb_robid, slb_value} : slb_head_s;
    alu_has_s  = ~alu_empty_s | alu_acc_s;
    slb_has_s  = ~slb_empty_s | slb_acc_s;
`else
    alu_cand_s = alu_head_s;
    slb_cand_s = slb_head_s;
    alu_has_s  = ~alu_empty_s;
    slb_has_s  = ~slb_empty_s;
`endif
  end

  // Grant selection and queue push/pop control for this cycle.
  always_comb begin
    grant_s    = rdy & ~flush_s & (alu_has_s | slb_has_s);
    winner_s   = pick_source(alu_has_s, slb_has_s, last_grant_r);
    alu_push_s = alu_acc_s;
    slb_push_s = slb_acc_s;
    alu_pop_s  = 1'b0;
    slb_pop_s  = 1'b0;
    win_data_s = '0;
    if (grant_s) begin
      if (winner_s == CDB_SRC_ALU) begin
        win_data_s = alu_cand_s;
`ifdef CDB_BYPASS_EN
        if (alu_empty_s) begin
          alu_push_s = 1'b0;
        end else begin
          alu_pop_s = 1'b1;
        end
`else
        alu_pop_s = 1'b1;
`endif
      end else begin
        win_data_s = slb_cand_s;
`ifdef CDB_BYPASS_EN
        if (slb_empty_s) begin
          slb_push_s = 1'b0;
        end else begin
          slb_pop_s = 1'b1;
        end
`else
        slb_pop_s = 1'b1;
`endif
      end
    end else begin
      win_data_s = '0;
    end
  end

  // CDB output registers and round-robin history; flush beats stall beats grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid    <= 1'b0;
      cdb_value    <= 32'd0;
      cdb_robid    <= '0;
      cdb_src      <= 1'b0;
      last_grant_r <= CDB_SRC_SLB;
    end else if (pred_fail_flag) begin
      cdb_valid    <= 1'b0;
      last_grant_r <= CDB_SRC_SLB;
    end else if (!rdy) begin
      cdb_valid    <= cdb_valid;
      last_grant_r <= last_grant_r;
    end else if (grant_s) begin
      cdb_valid    <= 1'b1;
      cdb_value    <= win_data_s[31:0];
      cdb_robid    <= win_data_s[ENT_W-1:32];
      cdb_src      <= winner_s;
      last_grant_r <= winner_s;
    end else begin
      cdb_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios plus randomized traffic
// checked cycle by cycle against a queue-based reference model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int QD = 2;
  localparam int RW = ROB_SIZE_LOG;
`ifdef CDB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef logic [RW+31:0] ent_t;
  typedef logic [RW+32:0] obs_t;

  logic          clk, rst, rdy, pred_fail_flag;
  logic          alu_valid, alu_ready, slb_valid, slb_ready;
  logic [31:0]   alu_value, slb_value, cdb_value;
  logic [RW-1:0] alu_robid, slb_robid, cdb_robid;
  logic          cdb_valid, cdb_src;

  int checks = 0;
  int errors = 0;

  // reference model state
  ent_t          mq_a[$];
  ent_t          mq_s[$];
  logic          m_last;
  logic          m_valid, m_src;
  logic [RW-1:0] m_robid;
  logic [31:0]   m_value;
  int            m_acc;

  // rdy-gated consumer
  obs_t seen_q[$];
  int   seen_cnt[16];

  cdb_arbiter #(.QUEUE_DEPTH(QD), .ROB_W(RW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .pred_fail_flag(pred_fail_flag),
    .alu_valid(alu_valid), .alu_value(alu_value), .alu_robid(alu_robid), .alu_ready(alu_ready),
    .slb_valid(slb_valid), .slb_value(slb_value), .slb_robid(slb_robid), .slb_ready(slb_ready),
    .cdb_valid(cdb_valid), .cdb_value(cdb_value), .cdb_robid(cdb_robid), .cdb_src(cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // consumer: a result counts only when sampled with rdy high
  always @(posedge clk) begin
    if (!rst && rdy && cdb_valid) begin
      seen_q.push_back({cdb_src, cdb_robid, cdb_value});
      seen_cnt[cdb_robid] = seen_cnt[cdb_robid] + 1;
    end
  end

  // One clock of the reference model, from the rules: flush > stall > serve.
  task automatic model_step();
    logic a_acc, s_acc, w;
    ent_t e;
    if (rst || pred_fail_flag) begin
      mq_a.delete(); mq_s.delete();
      m_valid = 1'b0; m_last = 1'b1;
      if (rst) begin m_src = 1'b0; m_robid = '0; m_value = 32'd0; end
    end else if (rdy) begin
      a_acc = alu_valid && (mq_a.size() < QD);
      s_acc = slb_valid && (mq_s.size() < QD);
      m_acc = m_acc + int'(a_acc) + int'(s_acc);
`ifdef CDB_BYPASS_EN
      if (a_acc) mq_a.push_back({alu_robid, alu_value});
      if (s_acc) mq_s.push_back({slb_robid, slb_value});
`endif
      if (mq_a.size() > 0 && mq_s.size() > 0) w = ~m_last;
      else w = (mq_a.size() == 0);
      if (mq_a.size() + mq_s.size() > 0) begin
        e = w ? mq_s.pop_front() : mq_a.pop_front();
        m_valid = 1'b1; m_src = w; m_robid = e[RW+31:32]; m_value = e[31:0]; m_last = w;
      end else begin
        m_valid = 1'b0;
      end
`ifndef CDB_BYPASS_EN
      if (a_acc) mq_a.push_back({alu_robid, alu_value});
      if (s_acc) mq_s.push_back({slb_robid, slb_value});
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic av, input logic [RW-1:0] ar, input logic [31:0] ad,
                       input logic sv, input logic [RW-1:0] sr, input logic [31:0] sd);
    alu_valid = av; alu_robid = ar; alu_value = ad;
    slb_valid = sv; slb_robid = sr; slb_value = sd;
    #1;
  endtask

  task automatic clear_seen();
    seen_q.delete();
    foreach (seen_cnt[i]) seen_cnt[i] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; pred_fail_flag = 1'b0; rdy = 1'b1;
    drive(1'b0, '0, 32'd0, 1'b0, '0, 32'd0);
    tick(); tick();
    rst = 1'b0;
    clear_seen();
  endtask

  task automatic test_reset();
    rst = 1'b1; pred_fail_flag = 1'b0; rdy = 1'b1;
    drive(1'b1, 4'd9, 32'hDEAD, 1'b1, 4'd10, 32'hBEEF);
    tick(); tick();
    rst = 1'b0;
    drive(1'b0, '0, 32'd0, 1'b0, '0, 32'd0);
    checks++;
    if ({cdb_valid, cdb_src, cdb_robid, cdb_value} !== {1'b0, 1'b0, 4'd0, 32'd0}) begin
      errors++; $display("FAIL reset_cdb: got %b/%b/%h/%h want 0/0/0/0", cdb_valid, cdb_src, cdb_robid, cdb_value);
    end
    checks++;
    if ({alu_ready, slb_ready} !== 2'b11) begin
      errors++; $display("FAIL reset_ready: got %b%b want 11", alu_ready, slb_ready);
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++; $display("FAIL reset_drop: cdb_valid got %b want 0", cdb_valid);
    end
  endtask

  task automatic test_alu_stream();
    int got = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k < 4) drive(1'b1, RW'(k + 1), 32'h10 + k, 1'b0, '0, 32'd0);
      else drive(1'b0, '0, 32'd0, 1'b0, '0, 32'd0);
      tick();
      if (cdb_valid === 1'b1) begin
        checks++;
        if ({cdb_src, cdb_robid, cdb_value} !== {1'b0, RW'(got + 1), 32'h10 + got}) begin
          errors++; $display("FAIL alu_stream_data: got %b/%h/%h want 0/%h/%h", cdb_src, cdb_robid, cdb_value, got + 1, 32'h10 + got);
        end
        if (got == 0) begin
          checks++;
          if (k + 1 != LAT) begin
            errors++; $display("FAIL alu_stream_latency: got %0d want %0d", k + 1, LAT);
          end
        end
        got++;
      end
    end
    checks++;
    if (got != 4) begin
      errors++; $display("FAIL alu_stream_count: got %0d want 4", got);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive(1'b1, 4'd3, 32'hAAAA, 1'b1, 4'd5, 32'h5555);
    tick();
    drive(1'b0, '0, 32'd0, 1'b0, '0, 32'd0);
    for (int k = 1; k < LAT; k++) tick();
    checks++;
    if ({cdb_valid, cdb_src, cdb_robid, cdb_value} !== {1'b1, 1'b0, 4'd3, 32'hAAAA}) begin
      errors++; $display("FAIL simul_first: got %b/%b/%h/%h want 1/0/3/0000aaaa", cdb_valid, cdb_src, cdb_robid, cdb_value);
    end
    tick();
    checks++;
    if ({cdb_valid, cdb_src, cdb_robid, cdb_value} !== {1'b1, 1'b1, 4'd5, 32'h5555}) begin
      errors++; $display("FAIL simul_second: got %b/%b/%h/%h want 1/1/5/00005555", cdb_valid, cdb_src, cdb_robid, cdb_value);
    end
  endtask

  task automatic test_saturation();
    logic prev_v = 1'b0, prev_s = 1'b0;
    int   not_ready = 0, bad_alt = 0;
    do_reset();
    m_acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) drive(1'b1, RW'(i), 32'h100 + i, 1'b1, RW'(i), 32'h200 + i);
      else drive(1'b0, '0, 32'd0, 1'b0, '0, 32'd0);
      checks++;
      if ({alu_ready, slb_ready} !== {rdy && (mq_a.size() < QD), rdy && (mq_s.size() < QD)}) begin
        errors++; $display("FAIL sat_ready: got %b%b sizes %0d %0d", alu_ready, slb_ready, mq_a.size(), mq_s.size());
      end
      if (!alu_ready || !slb_ready) not_ready++;
      tick();
      checks++;
      if ({cdb_valid, cdb_src, cdb_robid, cdb_value} !== {m_valid, m_src, m_robid, m_value}) begin
        errors++; $display("FAIL sat_cdb: got %b/%b/%h/%h want %b/%b/%h/%h", cdb_valid, cdb_src, cdb_robid, cdb_value, m_valid, m_src, m_robid, m_value);
      end
      if (i < 16 && prev_v && cdb_valid && prev_s == cdb_src) bad_alt++;
      prev_v = cdb_valid; prev_s = cdb_src;
    end
    checks++;
    if (bad_alt != 0 || not_ready == 0) begin
      errors++; $display("FAIL sat_alternate: repeats %0d readylow %0d want 0 and >0", bad_alt, not_ready);
    end
    checks++;
    if (seen_q.size() != m_acc) begin
      errors++; $display("FAIL sat_delivered: got %0d want %0d", seen_q.size(), m_acc);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 4'd1, 32'h31, 1'b0, '0, 32'd0);
    tick();
    drive(1'b1, 4'd2, 32'h32, 1'b1, 4'd9, 32'h39);
    tick();
    pred_fail_flag = 1'b1;
    drive(1'b1, 4'd12, 32'h3C, 1'b1, 4'd12, 32'h3C);
    tick();
    pred_fail_flag = 1'b0;
    drive(1'b0, '0, 32'd0, 1'b0, '0, 32'd0);
    checks++;
    if ({cdb_valid, alu_ready, slb_ready} !== 3'b011) begin
      errors++; $display("FAIL flush_state: valid/ready got %b%b%b want 011", cdb_valid, alu_ready, slb_ready);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (cdb_valid !== 1'b0) begin
        errors++; $display("FAIL flush_stale: robid %h broadcast after flush", cdb_robid);
      end
    end
  endtask

  task automatic test_rdy_stall();
    logic sent8 = 1'b0;
    do_reset();
    drive(1'b1, 4'd7, 32'h77, 1'b0, '0, 32'd0);
    tick();
    if (LAT == 2) begin
      drive(1'b1, 4'd8, 32'h88, 1'b0, '0, 32'd0);
      tick();
      sent8 = 1'b1;
    end
    checks++;
    if ({cdb_valid, cdb_robid} !== {1'b1, 4'd7}) begin
      errors++; $display("FAIL stall_pre: got %b/%h want 1/7", cdb_valid, cdb_robid);
    end
    rdy = 1'b0;
    drive(1'b0, '0, 32'd0, 1'b0, '0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({cdb_valid, cdb_robid, cdb_value, alu_ready, slb_ready} !== {1'b1, 4'd7, 32'h77, 2'b00}) begin
        errors++; $display("FAIL stall_hold: got %b/%h/%h ready %b%b want 1/7/77 ready 00", cdb_valid, cdb_robid, cdb_value, alu_ready, slb_ready);
      end
    end
    rdy = 1'b1;
    if (!sent8) drive(1'b1, 4'd8, 32'h88, 1'b0, '0, 32'd0);
    tick();
    drive(1'b0, '0, 32'd0, 1'b0, '0, 32'd0);
    checks++;
    if ({cdb_valid, cdb_robid, cdb_value} !== {1'b1, 4'd8, 32'h88}) begin
      errors++; $display("FAIL stall_next: got %b/%h/%h want 1/8/88", cdb_valid, cdb_robid, cdb_value);
    end
    tick();
    checks++;
    if (seen_cnt[7] != 1 || seen_cnt[8] != 1) begin
      errors++; $display("FAIL stall_count: robid7 seen %0d robid8 seen %0d want 1 1", seen_cnt[7], seen_cnt[8]);
    end
  endtask

  task automatic test_wraparound();
    obs_t exp_o;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, RW'(i), 32'hC0 + i, 1'b0, '0, 32'd0);
      tick();
      if ($urandom_range(0, 1) == 1) begin
        drive(1'b0, '0, 32'd0, 1'b0, '0, 32'd0);
        tick();
      end
    end
    drive(1'b0, '0, 32'd0, 1'b0, '0, 32'd0);
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (seen_q.size() != 10) begin
      errors++; $display("FAIL wrap_count: got %0d want 10", seen_q.size());
    end
    for (int i = 0; i < seen_q.size() && i < 10; i++) begin
      exp_o = {1'b0, RW'(i), 32'hC0 + i};
      checks++;
      if (seen_q[i] !== exp_o) begin
        errors++; $display("FAIL wrap_order[%0d]: got %h want %h", i, seen_q[i], exp_o);
      end
    end
    checks++;
    if ({alu_ready, cdb_valid} !== 2'b10) begin
      errors++; $display("FAIL wrap_empty: ready/valid got %b%b want 10", alu_ready, cdb_valid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst            = ($urandom_range(0, 99) == 0);
      pred_fail_flag = ($urandom_range(0, 99) < 3);
      rdy            = ($urandom_range(0, 99) < 85);
      drive($urandom_range(0, 99) < 60, RW'($urandom), $urandom,
            $urandom_range(0, 99) < 60, RW'($urandom), $urandom);
      if (!rst) begin
        checks++;
        if ({alu_ready, slb_ready} !== {rdy && (mq_a.size() < QD), rdy && (mq_s.size() < QD)}) begin
          errors++; $display("FAIL rand_ready[%0d]: got %b%b sizes %0d %0d", i, alu_ready, slb_ready, mq_a.size(), mq_s.size());
        end
      end
      tick();
      checks++;
      if ({cdb_valid, cdb_src, cdb_robid, cdb_value} !== {m_valid, m_src, m_robid, m_value}) begin
        errors++; $display("FAIL rand_cdb[%0d]: got %b/%b/%h/%h want %b/%b/%h/%h", i, cdb_valid, cdb_src, cdb_robid, cdb_value, m_valid, m_src, m_robid, m_value);
      end
    end
    rst = 1'b0; pred_fail_flag = 1'b0; rdy = 1'b1;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; pred_fail_flag = 1'b0;
    alu_valid = 1'b0; alu_robid = '0; alu_value = 32'd0;
    slb_valid = 1'b0; slb_robid = '0; slb_value = 32'd0;
    m_last = 1'b1; m_valid = 1'b0; m_src = 1'b0; m_robid = '0; m_value = 32'd0; m_acc = 0;
    clear_seen();
    test_reset();
    test_alu_stream();
    test_simultaneous();
    test_saturation();
    test_flush();
    test_rdy_stall();
    test_wraparound();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Completion-bus arbiter between execution units and the broadcast consumers (RS, SLB, ROB). Collects results from the ALU and the load path into small per-source queues and grants one result per cycle onto a single registered common data bus (CDB), round-robin when both sources are pending. All CDB consumers then watch one result port instead of two. Flushed on branch misprediction.

## Interface
- QUEUE_DEPTH, 2, entries per source queue (power of two, ≥2)
- ROB_W, `ROB_SIZE_LOG`, ROB index width
- Reset is `rst`: synchronous, active-high. Clock is `clk`.
- clk  in  1  clock
- rst  in  1  reset
- rdy  in  1  global enable; low freezes all state and outputs
- pred_fail_flag  in  1  flush: discard queued and in-flight results
- alu_valid  in  1  ALU result present
- alu_value  in  32  ALU result
- alu_robid  in  ROB_W  ALU destination ROB entry
- alu_ready  out  1  ALU queue can accept this cycle
- slb_valid  in  1  load result present
- slb_value  in  32  load data
- slb_robid  in  ROB_W  load destination ROB entry
- slb_ready  out  1  load queue can accept this cycle
- cdb_valid  out  1  broadcast valid, single-cycle pulse per result
- cdb_value  out  32  broadcast value
- cdb_robid  out  ROB_W  broadcast ROB entry
- cdb_src  out  1  0 = ALU, 1 = SLB

## Operation
- Per source: FIFO with head/tail pointers wrapping modulo QUEUE_DEPTH, count 0..QUEUE_DEPTH.
- Push when `x_valid && x_ready`. `x_ready = rdy && count < QUEUE_DEPTH`. A pop in the same cycle does not raise ready when the queue is full.
- `x_valid` while `!x_ready` is a protocol violation; the result is dropped and does not corrupt the queue.
- Arbitration over non-empty heads, at most one grant per cycle:
  - Only one source non-empty: that source wins.
  - Both non-empty: the source not in `last_grant` wins.
  - `last_grant` updates on every grant.
- Granted head is popped. `cdb_*` is registered from it, and `cdb_valid` is 1 for exactly one cycle.
- No grant: `cdb_valid <= 0`. `cdb_value`, `cdb_robid` and `cdb_src` hold their last values.
- Simultaneous push and pop on the same queue: count is unchanged, both pointers advance.
- Priority order: `rst` / `pred_fail_flag` > `!rdy` > normal operation.
- Flush (`rst` or `pred_fail_flag`):
  - Both queues emptied (pointers and count = 0), `cdb_valid <= 0`, `last_grant <= SLB`.
  - Inputs presented in the flush cycle are dropped.
- `!rdy`: no push, pop or grant. All registers hold, including a high `cdb_valid`. Consumers sample only under `rdy`, so each result is seen once.

## Timing
- Reset values: `cdb_valid` = 0, `cdb_value` = 0, `cdb_robid` = 0, `cdb_src` = 0. `alu_ready` / `slb_ready` = `rdy` (queues empty).
- Without bypass:
  - Result presented in cycle t is written to its queue at the end of t.
  - It is eligible for grant in t+1 and appears on the CDB in t+2.
  - Latency is 2 cycles.
- Sustained throughput is 1 result/cycle total. Under dual-source saturation each source gets 1 result per 2 cycles.
- A result granted in the cycle `pred_fail_flag` rises never reaches the CDB.

## Configuration
- `CDB_BYPASS_EN` defined:
  - An incoming result may skip its queue when that queue is empty and it wins arbitration in the same cycle. Arbitration treats it as that source's head.
  - It appears on the CDB in t+1 (latency 1).
  - A losing incoming result is enqueued normally.
- Undefined: every result passes through its queue, latency 2, and there is no combinational path from `x_valid` to the grant logic.

## Structure
- `utils.v` gains `CDB_SRC_ALU` (0) and `CDB_SRC_SLB` (1). `ROB_SIZE_LOG` is taken from it.
- Sub-module `result_fifo` holds value+robid storage, pointers, count and the full flag, with a flush input. It is instantiated twice.
- The top level holds the arbiter, `last_grant` and the CDB output registers.

## Test plan
- ALU-only stream: `alu_valid` for 4 cycles with robid 1..4 and values 0x10..0x13 → CDB pulses robid 1..4 in order, `cdb_src`=0, starting 2 cycles after the first input (1 cycle with `CDB_BYPASS_EN`).
- Simultaneous: ALU (robid 3, 0xAAAA) and SLB (robid 5, 0x5555) in the same cycle right after reset → ALU broadcast first, SLB the next cycle.
- Saturation: both sources valid every cycle with QUEUE_DEPTH=2 → each ready deasserts once its queue fills, grants alternate ALU/SLB, and no robid is lost or duplicated.
- Flush: queue 2 ALU + 1 SLB result, then pulse `pred_fail_flag` → `cdb_valid` is 0 the following cycle, both readys high, and no stale robid is ever broadcast.
- rdy stall: drop `rdy` for 3 cycles while `cdb_valid`=1 (robid 7) → outputs hold; after `rdy` returns, robid 7 is counted once by a rdy-gated checker and the next result follows.
- Wrap-around: push and pop 10 results through the ALU queue → values arrive in order across pointer wrap and count returns to 0.
